// File: rtl/fa4_word_sequencer_if.sv
// Request/result bus of the nibble-serial word adder.
//   master : requester side (drives start/sub/A/B/Cin, sees busy/done/Sum/Cout)
//   slave  : sequencer side (the opposite directions)
// NIBBLES sets the word width W = 4*NIBBLES.
interface fa4_word_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  modport master (output start, sub, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, sub, A, B, Cin, output busy, done, Sum, Cout);
endinterface

// File: rtl/fa4_word_sequencer.sv
// Multi-cycle (4*NIBBLES)-bit add/subtract on one shared 4-bit full adder.
// One nibble per cycle, LSB first, carry held in a flop between nibbles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of fa4_word_sequencer_if:
//        start/sub/A/B/Cin sampled in IDLE; busy high in RUN and DONE;
//        done one-cycle pulse with Sum/Cout, which hold until the next completion.

// 4-bit ripple-carry full adder slice.
module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

module fa4_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fa4_word_sequencer_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic [W-1:0]  a_reg, b_reg, acc, acc_nxt;
  logic          carry;
  logic [IW-1:0] idx;
  logic [3:0]    fa_a, fa_b, fa_s;
  logic          fa_co;

  assign fa_a = a_reg[4*idx +: 4];
  assign fa_b = b_reg[4*idx +: 4];

  fa4 u_fa4 (.a(fa_a), .b(fa_b), .ci(carry), .s(fa_s), .co(fa_co));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    acc_nxt = acc;
    // Merged accumulator: on the last nibble this is the complete result.
    acc_nxt[4*idx +: 4] = fa_s;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (idx == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Sum  <= '0;
      bus.Cout <= 1'b0;
    end else begin
      // busy/done registered off the next state so they track the FSM exactly.
      bus.busy <= (nxt != IDLE);
      bus.done <= (nxt == DONE);
      case (state)
        IDLE: if (bus.start) begin
          a_reg <= bus.A;
          // Subtract as A + ~B + 1; Cin is ignored for subtract.
          b_reg <= bus.sub ? ~bus.B : bus.B;
          carry <= bus.sub ? 1'b1 : bus.Cin;
          idx   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= fa_co;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            bus.Sum  <= acc_nxt;
            bus.Cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fa4_word_sequencer.sv
module tb_fa4_word_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fa4_word_sequencer_if #(.NIBBLES(4)) i4 ();
  fa4_word_sequencer_if #(.NIBBLES(1)) i1 ();

  fa4_word_sequencer #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(i4.slave));
  fa4_word_sequencer #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  typedef struct {
    logic [16:0] r;    // {Cout, Sum}
    int          acc;  // cycle count of the accepting edge
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   ndone4 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [16:0] r;
    logic [15:0] msk;
    msk = (w == 16) ? 16'hFFFF : 16'h000F;
    if (sub) r = {1'b0, a & msk} + {1'b0, ~b & msk} + 17'd1;
    else     r = {1'b0, a & msk} + {1'b0, b & msk} + {16'd0, cin};
    // Move the carry out of bit w into bit 16.
    if (w == 4) r = {r[4], 12'd0, r[3:0]};
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued op, at the right latency.
  always @(negedge clk) if (!rst) begin
    if (i4.done) begin
      ndone4++;
      chk("done4_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        exp_t e;
        e = q4.pop_front();
        chk("sum4", 32'(i4.Sum), 32'(e.r[15:0]));
        chk("cout4", 32'(i4.Cout), 32'(e.r[16]));
        chk("lat4", 32'(cyc - e.acc), 32'd4);
      end
    end
    if (i1.done) begin
      chk("done1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("sum1", 32'(i1.Sum), 32'(e.r[3:0]));
        chk("cout1", 32'(i1.Cout), 32'(e.r[16]));
        chk("lat1", 32'(cyc - e.acc), 32'd1);
      end
    end
  end

  // Single-pulse start on the 4-nibble unit; returns after the accepting edge.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic sub, input bit push);
    exp_t e;
    @(negedge clk);
    i4.A = a; i4.B = b; i4.Cin = cin; i4.sub = sub; i4.start = 1'b1;
    e.r = model(a, b, cin, sub, 16); e.acc = cyc + 1;
    if (push) q4.push_back(e);
    @(posedge clk); #1;
    i4.start = 1'b0;
    i4.A = 16'($urandom); i4.B = 16'($urandom); i4.Cin = 1'($urandom); i4.sub = 1'($urandom);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
    exp_t e;
    @(negedge clk);
    i1.A = a; i1.B = b; i1.Cin = cin; i1.sub = sub; i1.start = 1'b1;
    e.r = model({12'd0, a}, {12'd0, b}, cin, sub, 4); e.acc = cyc + 1;
    q1.push_back(e);
    @(posedge clk); #1;
    i1.start = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int nb;
    i4.start = 0; i4.sub = 0; i4.A = '0; i4.B = '0; i4.Cin = 0;
    i1.start = 0; i1.sub = 0; i1.A = '0; i1.B = '0; i1.Cin = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy4", 32'(i4.busy), 32'd0);
    chk("rst_done4", 32'(i4.done), 32'd0);
    chk("rst_sum4", 32'(i4.Sum), 32'd0);
    chk("rst_cout4", 32'(i4.Cout), 32'd0);
    chk("rst_busy1", 32'(i1.busy), 32'd0);

    // 1: basic add, busy width
    op4(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i4.busy) nb++;
      @(posedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'd5);
    drain(2);

    // 2: full ripple and carry-in only
    op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1); drain(7);
    op4(16'h0000, 16'h0000, 1'b1, 1'b0, 1); drain(7);

    // 3: subtract, Cin ignored
    op4(16'h0005, 16'h0007, 1'b1, 1'b1, 1); drain(7);
    op4(16'h0007, 16'h0005, 1'b0, 1'b1, 1); drain(7);

    // 4: start held high, operands scrambled during RUN
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      logic [15:0] a, b;
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      i4.A = a; i4.B = b; i4.Cin = k[0]; i4.sub = k[1]; i4.start = 1'b1;
      e.r = model(a, b, k[0], k[1], 16); e.acc = cyc + 1;
      q4.push_back(e);
      @(posedge clk); #1;
      i4.A = 16'($urandom); i4.B = 16'($urandom); i4.Cin = 1'($urandom); i4.sub = 1'($urandom);
      if (k < 2) repeat (5) @(posedge clk);
    end
    @(negedge clk) i4.start = 1'b0;
    drain(8);
    chk("held_done_count", 32'(ndone4), 32'd8);

    // 5: reset mid-RUN at idx==2
    op4(16'hAAAA, 16'h5555, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(i4.busy), 32'd0);
    chk("midrst_done", 32'(i4.done), 32'd0);
    chk("midrst_sum", 32'(i4.Sum), 32'd0);
    chk("midrst_cout", 32'(i4.Cout), 32'd0);
    drain(8);
    chk("midrst_no_done", 32'(ndone4), 32'd8);
    op4(16'h8000, 16'h8000, 1'b1, 1'b0, 1); drain(7);

    // 6: single-nibble instance
    op1(4'b0110, 4'b0100, 1'b0, 1'b0); drain(3);
    op1(4'b1000, 4'b1001, 1'b1, 1'b0); drain(3);
    op1(4'b0011, 4'b0101, 1'b0, 1'b1); drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
